// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl
//   Fetch sequencer for the instruction memory. Owns the byte PC, presents the
//   word address to a combinational instruction ROM every cycle, and captures
//   each returned word with its PC into a 2-entry in-order buffer that feeds
//   decode through a valid/ready handshake. Redirects from execute flush the
//   buffer and restart fetch at the target.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   fetch_en        permits new fetches; the buffer still drains when low
//   imem_addr       word address to instruction memory (pc[ADDR_WIDTH+1:2])
//   imem_data       instruction word returned combinationally for imem_addr
//   redirect_valid  one-cycle pulse: flush and restart at redirect_pc
//   redirect_pc     target byte address (bits [1:0] ignored)
//   if_valid        buffer head holds an instruction
//   if_ready        decode accepts the head this cycle
//   if_instr        head instruction, NOP (32'h13) when empty
//   if_pc           head byte PC, 0 when empty
//   busy            fetch running or buffer non-empty
module instr_fetch_ctrl #(
  parameter int          ADDR_WIDTH = 5,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_data,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [31:0]           if_instr,
  output logic [31:0]           if_pc,
  output logic                  busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];
  logic [1:0]  count;

  logic        pop;
  logic        push;
  logic        wr_idx;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = redirect_pc & ~32'h3;
  assign imem_addr    = pc[ADDR_WIDTH+1:2];

  // Head is always slot 0; outputs depend only on registered storage.
  assign if_valid = (count != 2'd0);
  assign if_instr = if_valid ? buf_instr[0] : NOP;
  assign if_pc    = if_valid ? buf_pc[0]    : '0;
  assign busy     = (state == RUN) || if_valid;

  assign pop  = if_valid & if_ready;
  assign push = (state == RUN) & fetch_en & ~redirect_valid &
                ((count < 2'd2) | pop);

  // Slot the new entry lands in after the optional shift caused by a pop.
  always_comb begin
    wr_idx = 1'b0;
    if (pop) wr_idx = (count == 2'd2);
    else     wr_idx = (count == 2'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      count <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
    end else begin
      state <= fetch_en ? RUN : IDLE;
      if (redirect_valid) begin
        count <= '0;
        pc    <= redirect_tgt;
      end else begin
        // Pop shifts slot 1 forward; a push into slot 0 in the same cycle
        // overrides the shift because it is the later assignment.
        if (pop) begin
          buf_pc[0]    <= buf_pc[1];
          buf_instr[0] <= buf_instr[1];
        end
        if (push) begin
          buf_pc[wr_idx]    <= pc;
          buf_instr[wr_idx] <= imem_data;
          pc                <= pc + 32'd4;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule
